banked_register_file: RTL

Parametrised integer register file for the RISC-V core with configurable read-port count and hardware register banks for nested interrupts. It sits in the decode stage: read addresses are sampled on the rising edge and registered values feed execute. The write-back stage writes on the same edge, with same-cycle write-to-read forwarding. Interrupt entry switches to a fresh bank carrying SP/FP over, and interrupt return switches back, so handlers need no software save/restore.

---
 rtl/banked_register_file.sv | 121 ++++++++++++
 1 files changed

// File: rtl/banked_register_file.sv
// Banked integer register file for the decode stage: registered reads with
// write-back bypass and a bank stack that is pushed and popped on interrupts.
module banked_register_file #(
  parameter int unsigned NUM_REG   = 32,
  parameter int unsigned SIZE_REG  = 64,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned SP_IDX    = 2,
  parameter int unsigned FP_IDX    = 8,
  parameter logic [63:0] SP_RESET  = 64'h87FFFFF0,
  parameter logic [63:0] FP_RESET  = 64'h88000000,
  localparam int unsigned AW = $clog2(NUM_REG),
  localparam int unsigned BW = $clog2(NUM_BANKS)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [NUM_RD*AW-1:0]       rs_addr_in,
  input  logic [AW-1:0]              rd_in,
  input  logic [SIZE_REG-1:0]        wr_data_in,
  input  logic                       rd_write_signal_in,
  input  logic                       stall_signal_in,
  input  logic                       flush_signal_in,
  input  logic                       interrupt_signal_in,
  input  logic                       return_interrupt_signal_in,
  output logic [NUM_RD*SIZE_REG-1:0] rs_value_out,
  output logic [BW-1:0]              bank_out,
  output logic                       nest_overflow_out,
  output logic                       nest_underflow_out
);

  logic [SIZE_REG-1:0] regs_q [NUM_BANKS][NUM_REG];
  logic [SIZE_REG-1:0] rs_q [NUM_RD];
  logic [BW-1:0]       bank_q, bank_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                we, push, pop, at_top, at_bot;
  logic [SIZE_REG-1:0] sp_fwd, fp_fwd;

  assign we     = rd_write_signal_in && (rd_in != '0);
  assign at_top = (bank_q == BW'(NUM_BANKS - 1));
  assign at_bot = (bank_q == '0);

  always_comb begin
    bank_d = bank_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    push   = 1'b0;
    pop    = 1'b0;
    if (interrupt_signal_in && !return_interrupt_signal_in) begin
      if (at_top) ovf_d = 1'b1;
      else begin
        push   = 1'b1;
        bank_d = bank_q + BW'(1);
      end
    end else if (return_interrupt_signal_in && !interrupt_signal_in) begin
      if (at_bot) unf_d = 1'b1;
      else begin
        pop    = 1'b1;
        bank_d = bank_q - BW'(1);
      end
    end
  end

  // SP/FP carried into the new bank see a same-edge write-back
  always_comb begin
    sp_fwd = regs_q[bank_q][SP_IDX];
    fp_fwd = regs_q[bank_q][FP_IDX];
    if (we && rd_in == AW'(SP_IDX)) sp_fwd = wr_data_in;
    if (we && rd_in == AW'(FP_IDX)) fp_fwd = wr_data_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bank_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      bank_q <= bank_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int b = 0; b < int'(NUM_BANKS); b++)
        for (int r = 0; r < int'(NUM_REG); r++)
          regs_q[b][r] <= '0;
      regs_q[0][SP_IDX] <= SIZE_REG'(SP_RESET);
      regs_q[0][FP_IDX] <= SIZE_REG'(FP_RESET);
    end else begin
      if (we) regs_q[bank_q][rd_in] <= wr_data_in;
      if (push) begin
        regs_q[bank_d][SP_IDX] <= sp_fwd;
        regs_q[bank_d][FP_IDX] <= fp_fwd;
      end
    end
  end

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [AW-1:0]       a;
    logic [SIZE_REG-1:0] v;
    assign a = rs_addr_in[k*AW +: AW];
    always_comb begin
      v = regs_q[bank_q][a];
      if (a == '0) v = '0;
      else if (we && a == rd_in) v = wr_data_in;
    end
    always_ff @(posedge clk_in) begin
      if (rst_in) rs_q[k] <= '0;
      else if (flush_signal_in) rs_q[k] <= '0;
      else if (!stall_signal_in) rs_q[k] <= v;
    end
    assign rs_value_out[k*SIZE_REG +: SIZE_REG] = rs_q[k];
  end

  assign bank_out           = bank_q;
  assign nest_overflow_out  = ovf_q;
  assign nest_underflow_out = unf_q;

endmodule
